// File: rtl/gshare_pkg.sv
// Shared constants and in-flight entry layout for the gshare predictor and its tracker.
package gshare_pkg;

  localparam int PC_W   = 7;
  localparam int HIST_W = 7;

  // One in-flight branch: its PC, the prediction handed to fetch, and the
  // pre-update global history the predictor used for that prediction.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              pred;
    logic [HIST_W-1:0] hist;
  } inflight_entry_t;

endpackage

// File: rtl/gshare_branch_tracker_if.sv
// Predict/train bus between the tracker (master) and the gshare predictor (slave).
interface gshare_branch_tracker_if;
  import gshare_pkg::*;

  logic              predict_valid;
  logic [PC_W-1:0]   predict_pc;
  logic              predict_taken;
  logic [HIST_W-1:0] predict_history;

  logic              train_valid;
  logic [PC_W-1:0]   train_pc;
  logic              train_taken;
  logic              train_mispredicted;
  logic [HIST_W-1:0] train_history;

  modport master (
    output predict_valid, predict_pc,
    input  predict_taken, predict_history,
    output train_valid, train_pc, train_taken, train_mispredicted, train_history
  );

  modport slave (
    input  predict_valid, predict_pc,
    output predict_taken, predict_history,
    input  train_valid, train_pc, train_taken, train_mispredicted, train_history
  );

endinterface

// File: rtl/branch_inflight_fifo.sv
// In-order queue of in-flight branches: push at tail, pop at head, clear on flush.
module branch_inflight_fifo
  import gshare_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  inflight_entry_t push_data,
  input  logic            pop,
  input  logic            clear,
  output inflight_entry_t head,
  output logic            full,
  output logic            empty,
  output logic [CNT_W-1:0] count
);

  inflight_entry_t  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping; clear drops every entry at once.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage write.
  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/gshare_branch_tracker.sv
// Fetch-side initiator for the gshare predictor: forwards predict requests,
// tracks in-flight branches in order, and issues train/flush on resolution.
module gshare_branch_tracker
  import gshare_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_valid,
  input  logic [PC_W-1:0]        fetch_pc,
  output logic                   fetch_ready,
  output logic                   fetch_pred_taken,
  input  logic                   resolve_valid,
  input  logic                   resolve_taken,
  output logic                   flush,
  output logic                   resolve_err,
  output logic [$clog2(DEPTH):0] count,
  gshare_branch_tracker_if.master bus
);

  inflight_entry_t head;
  inflight_entry_t push_entry;
  logic            full;
  logic            empty;
  logic            res_fire;
  logic            mispredict;
  logic            mp_fire;
  logic            push;

  // A mispredict flushes the queue this cycle, so a concurrent fetch is refused
  // rather than queued behind a flush that would discard it.
  assign res_fire    = resolve_valid && !empty;
  assign mispredict  = (head.pred != resolve_taken);
  assign mp_fire     = res_fire && mispredict;
  assign fetch_ready = !full && !mp_fire;
  assign push        = fetch_valid && fetch_ready;

  assign bus.predict_valid = push;
  assign bus.predict_pc    = fetch_pc;
  assign fetch_pred_taken  = bus.predict_taken;

  assign push_entry = '{pc: fetch_pc, pred: bus.predict_taken, hist: bus.predict_history};

  branch_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (res_fire),
    .clear     (mp_fire),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Train port, flush and error pulses, one cycle after resolution.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.train_valid        <= 1'b0;
      bus.train_pc           <= '0;
      bus.train_taken        <= 1'b0;
      bus.train_mispredicted <= 1'b0;
      bus.train_history      <= '0;
      flush                  <= 1'b0;
      resolve_err            <= 1'b0;
    end else begin
      bus.train_valid <= res_fire;
      flush           <= mp_fire;
      resolve_err     <= resolve_valid && empty;
      if (res_fire) begin
        bus.train_pc           <= head.pc;
        bus.train_history      <= head.hist;
        bus.train_taken        <= resolve_taken;
        bus.train_mispredicted <= mispredict;
      end
    end
  end

endmodule
